// File: rtl/msrv32_imm_stage_reg.sv
// Decode-to-execute pipeline register: captures PC, immediate and instr[24:0] in a 2-entry skid buffer.
// Latency: 1 cycle from upstream transfer to m_valid_out when empty; 1 beat/cycle sustained with m_ready_in high.
// Backpressure: s_ready_out is registered (= skid entry empty); it never depends on m_ready_in in the same cycle.
//
// Ports:
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_in : clock, async active-low reset
//   flush_in                                    : squash all held entries (taken branch/jump)
//   s_valid_in / s_ready_out / pc_in / instr_in / imm_in : upstream beat from decode / imm generator
//   m_valid_out / m_ready_in / pc_out / imm_out / *_out  : downstream beat to execute
//   occupancy_out                               : number of valid entries held (0..2)
module msrv32_imm_stage_reg #(
    parameter int XLEN = 32
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_in,
    input  logic            flush_in,
    input  logic            s_valid_in,
    output logic            s_ready_out,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] imm_in,
    output logic            m_valid_out,
    input  logic            m_ready_in,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] imm_out,
    output logic [6:0]      opcode_out,
    output logic [4:0]      rd_addr_out,
    output logic [2:0]      funct3_out,
    output logic [4:0]      rs1_addr_out,
    output logic [4:0]      rs2_addr_out,
    output logic [1:0]      occupancy_out
);

    // Main entry drives the outputs; skid entry holds the younger beat while execute stalls.
    logic            r_main_vld;
    logic [XLEN-1:0] r_main_pc;
    logic [XLEN-1:0] r_main_imm;
    logic [24:0]     r_main_instr;

    logic            r_skid_vld;
    logic [XLEN-1:0] r_skid_pc;
    logic [XLEN-1:0] r_skid_imm;
    logic [24:0]     r_skid_instr;

    logic            r_s_rdy;

    logic            w_up_xfer;
    logic            w_dn_xfer;

    assign w_up_xfer = s_valid_in & r_s_rdy;
    assign w_dn_xfer = r_main_vld & m_ready_in;

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            r_main_vld   <= 1'b0;
            r_main_pc    <= '0;
            r_main_imm   <= '0;
            r_main_instr <= '0;
            r_skid_vld   <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_imm   <= '0;
            r_skid_instr <= '0;
            r_s_rdy      <= 1'b1;
        end else if (flush_in) begin
            // Squash only the valid bits; payload keeps its last value.
            // An offered beat is dropped and a concurrent downstream
            // transfer has already been taken by execute.
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_s_rdy    <= 1'b1;
        end else if (!r_main_vld) begin
            // EMPTY: skid is necessarily empty here.
            if (w_up_xfer) begin
                r_main_vld   <= 1'b1;
                r_main_pc    <= pc_in;
                r_main_imm   <= imm_in;
                r_main_instr <= instr_in[24:0];
            end
        end else if (!r_skid_vld) begin
            // ONE
            if (w_up_xfer && w_dn_xfer) begin
                r_main_pc    <= pc_in;
                r_main_imm   <= imm_in;
                r_main_instr <= instr_in[24:0];
            end else if (w_up_xfer) begin
                r_skid_vld   <= 1'b1;
                r_skid_pc    <= pc_in;
                r_skid_imm   <= imm_in;
                r_skid_instr <= instr_in[24:0];
                r_s_rdy      <= 1'b0;
            end else if (w_dn_xfer) begin
                r_main_vld <= 1'b0;
            end
        end else begin
            // FULL: s_ready is low so no upstream transfer can occur.
            if (w_dn_xfer) begin
                r_main_pc    <= r_skid_pc;
                r_main_imm   <= r_skid_imm;
                r_main_instr <= r_skid_instr;
                r_skid_vld   <= 1'b0;
                r_s_rdy      <= 1'b1;
            end
        end
    end

    assign s_ready_out   = r_s_rdy;
    assign m_valid_out   = r_main_vld;
    assign pc_out        = r_main_pc;
    assign imm_out       = r_main_imm;
    assign opcode_out    = r_main_instr[6:0];
    assign rd_addr_out   = r_main_instr[11:7];
    assign funct3_out    = r_main_instr[14:12];
    assign rs1_addr_out  = r_main_instr[19:15];
    assign rs2_addr_out  = r_main_instr[24:20];
    // Skid valid implies main valid, so the count is {skid, main & ~skid}.
    assign occupancy_out = {r_skid_vld, r_main_vld & ~r_skid_vld};

endmodule

// File: tb/tb_msrv32_imm_stage_reg.sv
module tb_msrv32_imm_stage_reg;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic [31:0] imm_in;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] pc_out;
    logic [31:0] imm_out;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  occ;

    int n_cmp = 0;
    int n_err = 0;

    msrv32_imm_stage_reg #(.XLEN(32)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .flush_in             (flush),
        .s_valid_in           (s_valid),
        .s_ready_out          (s_ready),
        .pc_in                (pc_in),
        .instr_in             (instr_in),
        .imm_in               (imm_in),
        .m_valid_out          (m_valid),
        .m_ready_in           (m_ready),
        .pc_out               (pc_out),
        .imm_out              (imm_out),
        .opcode_out           (opcode),
        .rd_addr_out          (rd),
        .funct3_out           (funct3),
        .rs1_addr_out         (rs1),
        .rs2_addr_out         (rs2),
        .occupancy_out        (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic offer(input logic vld, input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] imm);
        s_valid  = vld;
        pc_in    = pc;
        instr_in = instr;
        imm_in   = imm;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0;
        offer(1'b0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
        n_cmp++; if (occ !== 2'd0) begin n_err++; $display("FAIL reset_occ got=%0d exp=0", occ); end
        n_cmp++; if (pc_out !== 32'h0 || imm_out !== 32'h0) begin n_err++; $display("FAIL reset_payload pc=%h imm=%h exp=0", pc_out, imm_out); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_beat();
        m_ready = 1'b1;
        offer(1'b1, 32'h00000010, 32'h81234567, 32'hFFFFF812);
        @(negedge clk);
        offer(1'b0, 32'h0, 32'h0, 32'h0);
        n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL single_m_valid got=%b exp=1", m_valid); end
        n_cmp++; if (pc_out !== 32'h10) begin n_err++; $display("FAIL single_pc got=%h exp=00000010", pc_out); end
        n_cmp++; if (imm_out !== 32'hFFFFF812) begin n_err++; $display("FAIL single_imm got=%h exp=fffff812", imm_out); end
        n_cmp++; if (opcode !== 7'h67) begin n_err++; $display("FAIL single_opcode got=%h exp=67", opcode); end
        n_cmp++; if (rd !== 5'd10) begin n_err++; $display("FAIL single_rd got=%0d exp=10", rd); end
        n_cmp++; if (funct3 !== 3'd4) begin n_err++; $display("FAIL single_funct3 got=%0d exp=4", funct3); end
        n_cmp++; if (rs1 !== 5'd6) begin n_err++; $display("FAIL single_rs1 got=%0d exp=6", rs1); end
        n_cmp++; if (rs2 !== 5'd18) begin n_err++; $display("FAIL single_rs2 got=%0d exp=18", rs2); end
        n_cmp++; if (occ !== 2'd1) begin n_err++; $display("FAIL single_occ got=%0d exp=1", occ); end
        @(negedge clk);
        n_cmp++; if (m_valid !== 1'b0 || occ !== 2'd0) begin n_err++; $display("FAIL single_drain m_valid=%b occ=%0d exp=0/0", m_valid, occ); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3];
        logic [31:0] instrs [3];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
        // rd fields 1, 2, 3 with opcode 0x13
        instrs[0] = 32'h00000093; instrs[1] = 32'h00000113; instrs[2] = 32'h00000193;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, pcs[i], instrs[i], 32'(i + 7));
            @(negedge clk);
            n_cmp++; if (m_valid !== 1'b1 || pc_out !== pcs[i]) begin n_err++; $display("FAIL b2b_beat%0d m_valid=%b pc=%h exp=1/%h", i, m_valid, pc_out, pcs[i]); end
            n_cmp++; if (rd !== 5'(i + 1) || imm_out !== 32'(i + 7)) begin n_err++; $display("FAIL b2b_fields%0d rd=%0d imm=%h exp=%0d/%h", i, rd, imm_out, i + 1, i + 7); end
            n_cmp++; if (s_ready !== 1'b1 || occ > 2'd1) begin n_err++; $display("FAIL b2b_ctrl%0d s_ready=%b occ=%0d exp=1/<=1", i, s_ready, occ); end
        end
        offer(1'b0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain m_valid=%b exp=0", m_valid); end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        offer(1'b1, 32'h20, 32'h0, 32'hA);
        @(negedge clk);
        n_cmp++; if (occ !== 2'd1 || s_ready !== 1'b1 || pc_out !== 32'h20) begin n_err++; $display("FAIL bp_one occ=%0d s_ready=%b pc=%h exp=1/1/20", occ, s_ready, pc_out); end
        offer(1'b1, 32'h24, 32'h0, 32'hB);
        @(negedge clk);
        n_cmp++; if (occ !== 2'd2 || s_ready !== 1'b0) begin n_err++; $display("FAIL bp_full occ=%0d s_ready=%b exp=2/0", occ, s_ready); end
        n_cmp++; if (pc_out !== 32'h20 || imm_out !== 32'hA || m_valid !== 1'b1) begin n_err++; $display("FAIL bp_a_stable pc=%h imm=%h vld=%b exp=20/a/1", pc_out, imm_out, m_valid); end
        offer(1'b1, 32'h28, 32'h0, 32'hC);
        @(negedge clk);
        n_cmp++; if (occ !== 2'd2 || s_ready !== 1'b0 || pc_out !== 32'h20) begin n_err++; $display("FAIL bp_c_held occ=%0d s_ready=%b pc=%h exp=2/0/20", occ, s_ready, pc_out); end
        m_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (pc_out !== 32'h24 || imm_out !== 32'hB || m_valid !== 1'b1) begin n_err++; $display("FAIL bp_b pc=%h imm=%h vld=%b exp=24/b/1", pc_out, imm_out, m_valid); end
        n_cmp++; if (s_ready !== 1'b1 || occ !== 2'd1) begin n_err++; $display("FAIL bp_ready_back s_ready=%b occ=%0d exp=1/1", s_ready, occ); end
        @(negedge clk);
        offer(1'b0, 32'h0, 32'h0, 32'h0);
        n_cmp++; if (pc_out !== 32'h28 || imm_out !== 32'hC || m_valid !== 1'b1) begin n_err++; $display("FAIL bp_c pc=%h imm=%h vld=%b exp=28/c/1", pc_out, imm_out, m_valid); end
        @(negedge clk);
        n_cmp++; if (m_valid !== 1'b0 || occ !== 2'd0) begin n_err++; $display("FAIL bp_drain m_valid=%b occ=%0d exp=0/0", m_valid, occ); end
    endtask

    task automatic test_flush();
        // Flush from FULL with a beat offered.
        m_ready = 1'b0;
        offer(1'b1, 32'h30, 32'h0, 32'h1);
        @(negedge clk);
        offer(1'b1, 32'h34, 32'h0, 32'h2);
        @(negedge clk);
        n_cmp++; if (occ !== 2'd2) begin n_err++; $display("FAIL flush_prefill occ=%0d exp=2", occ); end
        flush = 1'b1;
        offer(1'b1, 32'h38, 32'h0, 32'h3);
        @(negedge clk);
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0, 32'h0);
        n_cmp++; if (m_valid !== 1'b0 || occ !== 2'd0 || s_ready !== 1'b1) begin n_err++; $display("FAIL flush_full m_valid=%b occ=%0d s_ready=%b exp=0/0/1", m_valid, occ, s_ready); end
        n_cmp++; if (pc_out !== 32'h30) begin n_err++; $display("FAIL flush_payload_hold pc=%h exp=30", pc_out); end
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_ghost m_valid=%b exp=0", m_valid); end
        // Flush from ONE while s_ready is high: offered beat still dropped.
        m_ready = 1'b0;
        offer(1'b1, 32'h40, 32'h0, 32'h4);
        @(negedge clk);
        flush = 1'b1;
        offer(1'b1, 32'h44, 32'h0, 32'h5);
        @(negedge clk);
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0, 32'h0);
        n_cmp++; if (m_valid !== 1'b0 || occ !== 2'd0 || pc_out !== 32'h40) begin n_err++; $display("FAIL flush_one m_valid=%b occ=%0d pc=%h exp=0/0/40", m_valid, occ, pc_out); end
    endtask

    task automatic test_async_reset();
        m_ready = 1'b0;
        offer(1'b1, 32'h50, 32'h81234567, 32'h6);
        @(negedge clk);
        offer(1'b1, 32'h54, 32'h0, 32'h7);
        @(negedge clk);
        offer(1'b0, 32'h0, 32'h0, 32'h0);
        n_cmp++; if (occ !== 2'd2) begin n_err++; $display("FAIL arst_prefill occ=%0d exp=2", occ); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (m_valid !== 1'b0 || occ !== 2'd0 || s_ready !== 1'b1) begin n_err++; $display("FAIL arst_ctrl m_valid=%b occ=%0d s_ready=%b exp=0/0/1", m_valid, occ, s_ready); end
        n_cmp++; if (pc_out !== 32'h0 || imm_out !== 32'h0 || opcode !== 7'h0 || rd !== 5'h0 || funct3 !== 3'h0 || rs1 !== 5'h0 || rs2 !== 5'h0) begin
            n_err++; $display("FAIL arst_payload pc=%h imm=%h op=%h rd=%h f3=%h rs1=%h rs2=%h exp=all0", pc_out, imm_out, opcode, rd, funct3, rs1, rs2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        offer(1'b1, 32'h60, 32'h81234567, 32'h8);
        @(negedge clk);
        offer(1'b0, 32'h0, 32'h0, 32'h0);
        n_cmp++; if (m_valid !== 1'b1 || pc_out !== 32'h60 || opcode !== 7'h67) begin n_err++; $display("FAIL arst_after m_valid=%b pc=%h op=%h exp=1/60/67", m_valid, pc_out, opcode); end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_single_beat();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/msrv32_imm_stage_reg.md
Name: msrv32_imm_stage_reg

Overview:
- Decode-to-execute pipeline register sitting directly downstream of msrv32_imm_generator.
- Captures the generated immediate together with the PC and the instruction fields the execute stage needs (opcode, funct3, rd, rs1, rs2).
- Uses a 2-entry skid buffer with a valid/ready handshake on both sides, so back-pressure from execute never drops or duplicates an instruction.
- A flush input, asserted on a taken branch or jump, squashes everything in flight.

Parameters:
- XLEN, 32, datapath width of PC and immediate.

Ports:
- ms_riscv32_mp_clk_in  input  1  system clock; all state updates on the rising edge.
- ms_riscv32_mp_rst_in  input  1  asynchronous, active-low reset.
- flush_in  input  1  squash all held entries (taken branch/jump).
- s_valid_in  input  1  upstream beat valid.
- s_ready_out  output  1  block can accept a beat.
- pc_in  input  XLEN  PC of the instruction.
- instr_in  input  32  instruction word; the same word drives the immediate generator.
- imm_in  input  XLEN  imm_out of msrv32_imm_generator for instr_in.
- m_valid_out  output  1  downstream beat valid.
- m_ready_in  input  1  execute stage accepts the beat.
- pc_out  output  XLEN  registered PC.
- imm_out  output  XLEN  registered immediate.
- opcode_out  output  7  instr[6:0].
- rd_addr_out  output  5  instr[11:7].
- funct3_out  output  3  instr[14:12].
- rs1_addr_out  output  5  instr[19:15].
- rs2_addr_out  output  5  instr[24:20].
- occupancy_out  output  2  number of valid entries held (0, 1 or 2).

Behaviour:
- Storage:
  - Main entry (drives all m_* and field outputs) and skid entry. Each entry holds {pc, imm, instr[24:0]} plus a valid bit.
  - Field outputs are sliced from the main entry's stored instr bits. There is no combinational path from instr_in or imm_in to any output.
- Handshake:
  - An upstream transfer occurs when s_valid_in and s_ready_out are both high.
  - A downstream transfer occurs when m_valid_out and m_ready_in are both high.
- s_ready_out is a registered signal equal to "skid entry empty". It never depends combinationally on m_ready_in.
- States, encoded by occupancy: EMPTY (0), ONE (main valid), FULL (main and skid valid).
  - EMPTY: upstream transfer loads main -> ONE.
  - ONE, upstream transfer and downstream transfer together: main reloads with the new beat; stays ONE.
  - ONE, upstream transfer only (m_ready_in low): new beat goes to skid -> FULL; s_ready_out goes low next cycle.
  - ONE, downstream transfer only -> EMPTY.
  - FULL: no upstream transfer (s_ready_out low). Downstream transfer moves skid to main -> ONE; s_ready_out goes high next cycle.
- Ordering: strict FIFO; the skid entry is always younger than main.
- Latency: 1 cycle from upstream transfer to m_valid_out when EMPTY. Throughput is 1 beat per cycle while m_ready_in stays high.
- m_valid_out, once high, stays high with stable payload until a downstream transfer or flush_in.
- flush_in (synchronous, highest priority):
  - Next cycle: both valid bits 0, occupancy_out 0, s_ready_out 1.
  - A beat offered in the flush cycle is discarded even if s_ready_out was high.
  - A downstream transfer in the flush cycle still counts as consumed by execute.
- Payload registers are not cleared by flush; they hold their last value while invalid.
- Reset (ms_riscv32_mp_rst_in low, asserted asynchronously at any time, including mid-transfer):
  - m_valid_out 0, occupancy_out 0, s_ready_out 1.
  - pc_out, imm_out, opcode_out, rd/rs1/rs2/funct3 outputs all 0.
  - Reset release is synchronous to the clock edge; the first upstream transfer is allowed on the first rising edge after release.
- No arithmetic is performed. Widths pass through unchanged; XLEN=32 only is required.

Test Plan:
- Reset, then a single beat pc_in=32'h00000010, instr_in=32'h81234567, imm_in=32'hFFFFF812, m_ready_in=1 -> next cycle:
  - m_valid_out=1, pc_out=32'h10, imm_out=32'hFFFFF812, opcode_out=7'h67, rd_addr_out=10, funct3_out=4, rs1_addr_out=6, rs2_addr_out=18, occupancy_out=1.
- Back-to-back beats A, B, C with m_ready_in held at 1 -> outputs A, B, C on consecutive cycles; s_ready_out stays 1; occupancy_out never exceeds 1.
- m_ready_in=0 while A (pc 32'h20) and B (pc 32'h24) are sent:
  - occupancy_out=2 and s_ready_out=0; C (pc 32'h28) is held off and A stays stable.
  - Raising m_ready_in delivers A, B, C in order, with s_ready_out returning to 1 one cycle after A leaves.
- FULL state with flush_in=1 and a new beat offered in the same cycle -> next cycle m_valid_out=0, occupancy_out=0, s_ready_out=1; the beat offered in the flush cycle never appears at the output.
- Assert ms_riscv32_mp_rst_in low mid-cycle while FULL -> immediately m_valid_out=0, all payload outputs 0, s_ready_out=1; after release, a new beat passes with 1-cycle latency.
